// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator
// Bit-serial magnitude comparator. Captures two WIDTH-bit operands and a
// cascade input on an accepted start, scans them MSB-first one bit per clock,
// and reports "b greater than a, else cascade-in" plus an equality flag.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   start  - request, sampled only in IDLE
//   a, b   - operands, captured when start is accepted
//   cin    - cascade (tie) input, captured when start is accepted
//   busy   - high in RUN and DONE
//   done   - one-cycle pulse, result valid
//   w      - 1 if b>a, 0 if a>b, captured cin if a==b (held until next result)
//   eq     - 1 if a==b (held until next result)
//
// Optional feature macro: SERIAL_CMP_EARLY_EXIT_EN
//   When defined, RUN ends on the edge that finds the first differing bit.
//   Equal operands still scan all WIDTH bits. Results are identical.
module serial_magnitude_comparator #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic             w,
  output logic             eq
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sa_nxt;
  logic [WIDTH-1:0] sb, sb_nxt;
  logic             cin_q, cin_q_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             decided, decided_nxt;
  logic             res, res_nxt;
  logic             busy_nxt, done_nxt, w_nxt, eq_nxt;
  logic             hit;
  logic             last;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      sa      <= '0;
      sb      <= '0;
      cin_q   <= 1'b0;
      cnt     <= '0;
      decided <= 1'b0;
      res     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      w       <= 1'b0;
      eq      <= 1'b0;
    end else begin
      state   <= state_nxt;
      sa      <= sa_nxt;
      sb      <= sb_nxt;
      cin_q   <= cin_q_nxt;
      cnt     <= cnt_nxt;
      decided <= decided_nxt;
      res     <= res_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      w       <= w_nxt;
      eq      <= eq_nxt;
    end
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_nxt   = state;
    sa_nxt      = sa;
    sb_nxt      = sb;
    cin_q_nxt   = cin_q;
    cnt_nxt     = cnt;
    decided_nxt = decided;
    res_nxt     = res;
    w_nxt       = w;
    eq_nxt      = eq;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
    hit         = 1'b0;
    last        = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          sa_nxt      = a;
          sb_nxt      = b;
          cin_q_nxt   = cin;
          cnt_nxt     = CNT_W'(WIDTH);
          decided_nxt = 1'b0;
          res_nxt     = 1'b0;
          state_nxt   = RUN;
        end
      end

      RUN: begin
        // First differing bit fixes the result; later bits are ignored.
        hit = !decided && (sa[WIDTH-1] ^ sb[WIDTH-1]);
        if (hit) begin
          res_nxt     = sb[WIDTH-1];
          decided_nxt = 1'b1;
        end
        sa_nxt  = {sa[WIDTH-2:0], 1'b0};
        sb_nxt  = {sb[WIDTH-2:0], 1'b0};
        cnt_nxt = cnt - CNT_W'(1);
        last    = (cnt == CNT_W'(1));
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        last    = last || hit;
`endif
        if (last) begin
          state_nxt = DONE;
          // Uses the decision including the bit examined on this edge.
          w_nxt     = decided_nxt ? res_nxt : cin_q;
          eq_nxt    = !decided_nxt;
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench for serial_magnitude_comparator (WIDTH=8).
// Expected results are pushed to a scoreboard queue at launch and popped
// when done is observed. Honours SERIAL_CMP_EARLY_EXIT_EN for latency.
module tb_serial_magnitude_comparator;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic             w;
  logic             eq;

  typedef struct {
    logic w;
    logic eq;
    int   lat;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  logic last_w = 1'b0;
  logic last_eq = 1'b0;

  serial_magnitude_comparator #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .w     (w),
    .eq    (eq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edges from acceptance to DONE entry.
  function automatic int exp_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int lat;
    lat = WIDTH;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (x[i] != y[i]) begin
        lat = WIDTH - i;
        break;
      end
    end
`endif
    return lat;
  endfunction

  // Drive a start for one edge and push the expected result.
  task automatic launch(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic ic);
    exp_t e;
    a     = ia;
    b     = ib;
    cin   = ic;
    start = 1'b1;
    e.w   = (ib > ia) ? 1'b1 : ((ia > ib) ? 1'b0 : ic);
    e.eq  = (ia == ib);
    e.lat = exp_lat(ia, ib);
    sbq.push_back(e);
    step();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("w_hold_on_start", w, last_w);
    check("eq_hold_on_start", eq, last_eq);
  endtask

  // Wait for done (bounded), optionally re-pulsing start and scrambling inputs.
  task automatic finish_op(input logic [63:0] pulse_mask, input bit scramble);
    int   edges;
    int   busy_cycles;
    exp_t e;
    edges       = 0;
    busy_cycles = 1;
    if (scramble) begin
      a   = 8'h00;
      b   = 8'hFF;
      cin = ~cin;
    end
    while (!done && edges < 40) begin
      start = pulse_mask[edges + 1];
      step();
      start = 1'b0;
      edges++;
      if (busy) busy_cycles++;
    end
    if (!done) begin
      check("done_timeout", 0, 1);
      sbq.delete();
      return;
    end
    e = sbq.pop_front();
    check("w", w, e.w);
    check("eq", eq, e.eq);
    check("latency", edges, e.lat);
    check("busy_cycles", busy_cycles, e.lat + 1);
    last_w  = e.w;
    last_eq = e.eq;
    step();
    check("done_single_pulse", done, 0);
    check("busy_back_idle", busy, 0);
    check("w_hold_after_done", w, last_w);
    step();
    check("no_extra_op", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_w", w, 0);
    check("rst_eq", eq, 0);
    step();
    check("idle_busy", busy, 0);

    launch(8'h3C, 8'h5A, 1'b0);
    finish_op(64'h0, 1'b0);
    launch(8'hF0, 8'h0F, 1'b1);
    finish_op(64'h0, 1'b0);
    launch(8'hA5, 8'hA5, 1'b1);
    finish_op(64'h0, 1'b0);
    launch(8'hA5, 8'hA5, 1'b0);
    finish_op(64'h0, 1'b0);
    launch(8'h80, 8'h81, 1'b0);
    finish_op(64'h0, 1'b0);

    // Re-pulsed start at RUN edges N+2 and N+5; operands changed after capture.
    launch(8'h80, 8'h81, 1'b1);
    finish_op(64'h24, 1'b1);

    // Reset mid-RUN at edge N+4 abandons the operation.
    a     = 8'h80;
    b     = 8'h81;
    cin   = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("no_done_before_reset", done, 0);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_w", w, 0);
    check("midrst_eq", eq, 0);
    last_w  = 1'b0;
    last_eq = 1'b0;
    launch(8'h01, 8'h00, 1'b1);
    finish_op(64'h0, 1'b0);

    launch(8'h00, 8'h00, 1'b1);
    finish_op(64'h0, 1'b0);
    launch(8'hFF, 8'hFF, 1'b0);
    finish_op(64'h0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      launch(WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      finish_op(64'h0, 1'b0);
    end

    check("scoreboard_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
